// File: rtl/if_prefetch.sv
// Instruction-fetch front end with a prefetch FIFO.
// Issues pipelined Avalon-MM reads, tracks in-flight reads, and queues returned
// instructions with their PC toward the decode stage. Redirects flush the FIFO
// and discard every response that was already in flight.
module if_prefetch #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ibus_read,
  output logic [XLEN-1:0] ibus_address,
  input  logic            ibus_waitrequest,
  input  logic [XLEN-1:0] ibus_readdata,
  input  logic            ibus_readdatavalid,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instruction
);

  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 2);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FillW = PtrW + 1;

  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);
  localparam logic [XLEN-1:0] StartPc   = RESET_PC & AlignMask;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]  pending_pc_q, pending_pc_d;
  logic             redirect_pending_q, redirect_pending_d;
  logic             held_q, held_d;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [2*XLEN-1:0] fifo_mem [FIFO_DEPTH];

  logic            credit;
  logic            accept;
  logic            held_now;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] branch_target;

  // Bus issue and FIFO handshakes; credit reserves a FIFO slot for every in-flight read.
  always_comb begin
    credit        = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                    ((32'(fill_q) + 32'(outstanding_q)) < FIFO_DEPTH);
    ibus_read     = ~rst & (held_q | credit);
    ibus_address  = fetch_pc_q;
    accept        = ibus_read & ~ibus_waitrequest;
    held_now      = ibus_read & ibus_waitrequest;
    branch_target = branch_pc & AlignMask;
    out_valid     = (fill_q != '0);
    push          = ibus_readdatavalid & (drop_cnt_q == '0) & ~branch_take;
    pop           = out_valid & out_ready & ~branch_take;
    {out_pc, out_instruction} = fifo_mem[rd_ptr_q];
  end

  // Next-state: normal fetch/response bookkeeping, then redirect overrides.
  always_comb begin
    fetch_pc_d         = fetch_pc_q;
    resp_pc_d          = resp_pc_q;
    pending_pc_d       = pending_pc_q;
    redirect_pending_d = redirect_pending_q;
    held_d             = held_now;
    outstanding_d      = outstanding_q + CntW'(accept) - CntW'(ibus_readdatavalid);
    drop_cnt_d         = drop_cnt_q;
    fill_d             = fill_q + FillW'(push) - FillW'(pop);
    rd_ptr_d           = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d           = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;

    if (ibus_readdatavalid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + XLEN'(4);
    end

    if (accept) begin
      if (redirect_pending_q) begin
        // The stalled pre-redirect read just went out; its data must be discarded too.
        fetch_pc_d         = pending_pc_q;
        drop_cnt_d         = drop_cnt_d + CntW'(1);
        redirect_pending_d = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
    end

    if (branch_take) begin
      fill_d     = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      resp_pc_d  = branch_target;
      drop_cnt_d = outstanding_d;
      if (held_now) begin
        // Avalon forbids changing a stalled request, so defer the new target.
        fetch_pc_d         = fetch_pc_q;
        pending_pc_d       = branch_target;
        redirect_pending_d = 1'b1;
      end else begin
        fetch_pc_d         = branch_target;
        redirect_pending_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q         <= StartPc;
      resp_pc_q          <= StartPc;
      pending_pc_q       <= StartPc;
      redirect_pending_q <= 1'b0;
      held_q             <= 1'b0;
      outstanding_q      <= '0;
      drop_cnt_q         <= '0;
      fill_q             <= '0;
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
    end else begin
      fetch_pc_q         <= fetch_pc_d;
      resp_pc_q          <= resp_pc_d;
      pending_pc_q       <= pending_pc_d;
      redirect_pending_q <= redirect_pending_d;
      held_q             <= held_d;
      outstanding_q      <= outstanding_d;
      drop_cnt_q         <= drop_cnt_d;
      fill_q             <= fill_d;
      rd_ptr_q           <= rd_ptr_d;
      wr_ptr_q           <= wr_ptr_d;
    end
  end

  // FIFO storage; contents need no reset since fill count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {resp_pc_q, ibus_readdata};
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: Avalon slave model with programmable latency and
// waitrequest, and a scoreboard of expected {pc, instruction} pairs.
module tb_if_prefetch;

  localparam int MaxOut = 2;
  localparam int Depth  = 4;

  logic        clk;
  logic        rst;
  logic        ibus_read;
  logic [31:0] ibus_address;
  logic        ibus_waitrequest;
  logic [31:0] ibus_readdata;
  logic        ibus_readdatavalid;
  logic        branch_take;
  logic [31:0] branch_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;

  if_prefetch #(
    .XLEN           (32),
    .FIFO_DEPTH     (Depth),
    .MAX_OUTSTANDING(MaxOut),
    .RESET_PC       (32'h0)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ibus_read         (ibus_read),
    .ibus_address      (ibus_address),
    .ibus_waitrequest  (ibus_waitrequest),
    .ibus_readdata     (ibus_readdata),
    .ibus_readdatavalid(ibus_readdatavalid),
    .branch_take       (branch_take),
    .branch_pc         (branch_pc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_instruction   (out_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } req_t;

  req_t        sq[$];      // reads accepted by the slave, not yet answered
  logic [63:0] exp_q[$];   // expected {pc, instruction} in DUT FIFO order

  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  int          stall_cnt;
  int          n_pop;
  int          n_acc;
  bit          held_prev;
  logic [31:0] held_addr;
  logic [31:0] exp_fetch;
  bit          pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] last_pop_pc;
  logic [31:0] last_pop_instr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // One bus cycle: drive slave outputs, check DUT against the model, advance the model.
  task automatic cycle();
    bit          rsp;
    bit          acc;
    bit          hold;
    bit          exp_read;
    req_t        r;
    logic [63:0] e;
    logic [31:0] tgt;
    tgt = {branch_pc[31:2], 2'b00};
    ibus_waitrequest   = (stall_cnt > 0);
    rsp                = (sq.size() > 0) && (sq[0].due <= cyc);
    ibus_readdatavalid = rsp;
    ibus_readdata      = rsp ? mem_data(sq[0].addr) : 32'h0;
    #1;
    exp_read = held_prev || ((sq.size() < MaxOut) && (exp_q.size() + sq.size() < Depth));
    checks++;
    if (ibus_read !== exp_read) begin
      errors++;
      $display("FAIL ibus_read cyc %0d: got %b expected %b", cyc, ibus_read, exp_read);
    end
    if (held_prev) begin
      checks++;
      if (ibus_read !== 1'b1 || ibus_address !== held_addr) begin
        errors++;
        $display("FAIL held_request cyc %0d: got read %b addr %h expected 1 %h",
                 cyc, ibus_read, ibus_address, held_addr);
      end
    end
    acc  = ibus_read & ~ibus_waitrequest;
    hold = ibus_read & ibus_waitrequest;
    if (acc) begin
      checks++;
      if (ibus_address !== exp_fetch) begin
        errors++;
        $display("FAIL fetch_address cyc %0d: got %h expected %h", cyc, ibus_address, exp_fetch);
      end
    end
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_q.size() != 0);
    end
    if (out_valid === 1'b1 && out_ready && !branch_take && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_pc, out_instruction} !== e) begin
        errors++;
        $display("FAIL pop_data cyc %0d: got %h/%h expected %h/%h",
                 cyc, out_pc, out_instruction, e[63:32], e[31:0]);
      end
      n_pop++;
      last_pop_pc    = out_pc;
      last_pop_instr = out_instruction;
    end
    if (rsp) begin
      r = sq.pop_front();
      if (r.live && !branch_take) exp_q.push_back({r.addr, mem_data(r.addr)});
    end
    if (acc) begin
      sq.push_back('{addr: ibus_address, due: cyc + lat, live: !pend_valid});
      n_acc++;
      if (branch_take) begin
        exp_fetch  = tgt;
        pend_valid = 1'b0;
      end else if (pend_valid) begin
        exp_fetch  = pend_pc;
        pend_valid = 1'b0;
      end else begin
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (branch_take) begin
      foreach (sq[i]) sq[i].live = 1'b0;
      exp_q.delete();
      if (!acc) begin
        if (hold) begin
          pend_valid = 1'b1;
          pend_pc    = tgt;
        end else begin
          exp_fetch  = tgt;
          pend_valid = 1'b0;
        end
      end
    end
    held_prev = hold;
    held_addr = ibus_address;
    if (stall_cnt > 0) stall_cnt--;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    sq.delete();
    exp_q.delete();
    held_prev  = 1'b0;
    pend_valid = 1'b0;
    exp_fetch  = 32'h0;
    stall_cnt  = 0;
    lat        = 1;
    cyc        = 0;
    rst        = 1'b0;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    branch_take        = 1'b0;
    branch_pc          = 32'h0;
    ibus_waitrequest   = 1'b0;
    ibus_readdatavalid = 1'b0;
    out_ready          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    release_reset();
  endtask

  task automatic run_until_pop(input int start, output bit ok);
    for (int i = 0; i < 30; i++) begin
      if (n_pop > start) break;
      cycle();
    end
    ok = (n_pop > start);
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    branch_take        = 1'b0;
    branch_pc          = 32'h0;
    ibus_waitrequest   = 1'b0;
    ibus_readdatavalid = 1'b0;
    ibus_readdata      = 32'h0;
    out_ready          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ibus_read !== 1'b0 || out_valid !== 1'b0 || ibus_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got read %b valid %b addr %h expected 0 0 0",
               ibus_read, out_valid, ibus_address);
    end
    release_reset();
    #1;
    checks++;
    if (ibus_read !== 1'b1 || ibus_address !== 32'h0) begin
      errors++;
      $display("FAIL first_fetch: got read %b addr %h expected 1 00000000",
               ibus_read, ibus_address);
    end
  endtask

  task automatic test_stream();
    int p0;
    do_reset();
    repeat (3) cycle();
    p0 = n_pop;
    repeat (10) cycle();
    checks++;
    if (n_pop - p0 != 10) begin
      errors++;
      $display("FAIL stream_rate: got %0d pops expected 10", n_pop - p0);
    end
  endtask

  task automatic test_stall();
    int a0;
    int p0;
    do_reset();
    out_ready = 1'b0;
    a0 = n_acc;
    repeat (10) cycle();
    checks++;
    if (n_acc - a0 != 4) begin
      errors++;
      $display("FAIL stall_accepts: got %0d expected 4", n_acc - a0);
    end
    checks++;
    if (ibus_read !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0 ||
        ibus_address !== 32'h10) begin
      errors++;
      $display("FAIL stall_state: got read %b valid %b pc %h addr %h expected 0 1 0 10",
               ibus_read, out_valid, out_pc, ibus_address);
    end
    out_ready = 1'b1;
    p0 = n_pop;
    cycle();
    checks++;
    if (n_pop - p0 != 1 || last_pop_pc !== 32'h0) begin
      errors++;
      $display("FAIL stall_first_pop: got %0d pops pc %h expected 1 0", n_pop - p0, last_pop_pc);
    end
    repeat (3) cycle();
    checks++;
    if (n_pop - p0 != 4 || last_pop_pc !== 32'hC) begin
      errors++;
      $display("FAIL stall_drain: got %0d pops pc %h expected 4 c", n_pop - p0, last_pop_pc);
    end
    repeat (4) cycle();
  endtask

  task automatic test_waitrequest();
    do_reset();
    for (int i = 0; i < 10 && ibus_address !== 32'h8; i++) cycle();
    stall_cnt = 3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ibus_read !== 1'b1 || ibus_address !== 32'h8) begin
        errors++;
        $display("FAIL wait_hold %0d: got read %b addr %h expected 1 8",
                 i, ibus_read, ibus_address);
      end
      cycle();
    end
    checks++;
    if (ibus_address !== 32'hC) begin
      errors++;
      $display("FAIL wait_next_addr: got %h expected c", ibus_address);
    end
    repeat (4) cycle();
  endtask

  task automatic test_branch_outstanding();
    bit ok;
    int p0;
    do_reset();
    lat = 3;
    for (int i = 0; i < 10 && !(sq.size() == 2 && !held_prev); i++) cycle();
    checks++;
    if (sq.size() != 2) begin
      errors++;
      $display("FAIL br_setup: got %0d outstanding expected 2", sq.size());
    end
    branch_take = 1'b1;
    branch_pc   = 32'h102;
    cycle();
    branch_take = 1'b0;
    lat         = 1;
    checks++;
    if (out_valid !== 1'b0 || ibus_address !== 32'h100) begin
      errors++;
      $display("FAIL br_after: got valid %b addr %h expected 0 100", out_valid, ibus_address);
    end
    p0 = n_pop;
    run_until_pop(p0, ok);
    checks++;
    if (!ok || last_pop_pc !== 32'h100 || last_pop_instr !== mem_data(32'h100)) begin
      errors++;
      $display("FAIL br_first_pop: got ok %b pc %h data %h expected 1 100 %h",
               ok, last_pop_pc, last_pop_instr, mem_data(32'h100));
    end
    repeat (3) cycle();
  endtask

  task automatic test_branch_held();
    bit ok;
    int p0;
    do_reset();
    for (int i = 0; i < 10 && ibus_address !== 32'h10; i++) cycle();
    stall_cnt = 4;
    cycle();
    branch_take = 1'b1;
    branch_pc   = 32'h200;
    cycle();
    branch_take = 1'b0;
    for (int i = 0; i < 10 && ibus_address === 32'h10; i++) begin
      checks++;
      if (ibus_read !== 1'b1) begin
        errors++;
        $display("FAIL held_br_read %0d: got %b expected 1", i, ibus_read);
      end
      cycle();
    end
    checks++;
    if (ibus_address !== 32'h200 || ibus_read !== 1'b1) begin
      errors++;
      $display("FAIL held_br_next: got addr %h read %b expected 200 1", ibus_address, ibus_read);
    end
    p0 = n_pop;
    run_until_pop(p0, ok);
    checks++;
    if (!ok || last_pop_pc !== 32'h200) begin
      errors++;
      $display("FAIL held_br_pop: got ok %b pc %h expected 1 200", ok, last_pop_pc);
    end
    repeat (3) cycle();
  endtask

  task automatic test_branch_same_cycle();
    bit ok;
    int p0;
    do_reset();
    repeat (3) cycle();
    for (int i = 0; i < 10 && !(sq.size() > 0 && sq[0].due <= cyc && out_valid === 1'b1); i++)
      cycle();
    branch_take = 1'b1;
    branch_pc   = 32'h300;
    cycle();
    branch_take = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ibus_read !== 1'b1 || ibus_address !== 32'h300) begin
      errors++;
      $display("FAIL same_cycle_br: got valid %b read %b addr %h expected 0 1 300",
               out_valid, ibus_read, ibus_address);
    end
    p0 = n_pop;
    run_until_pop(p0, ok);
    checks++;
    if (!ok || last_pop_pc !== 32'h300) begin
      errors++;
      $display("FAIL same_cycle_pop: got ok %b pc %h expected 1 300", ok, last_pop_pc);
    end
    repeat (3) cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_pop  = 0;
    n_acc  = 0;
    test_reset();
    test_stream();
    test_stall();
    test_waitrequest();
    test_branch_outstanding();
    test_branch_held();
    test_branch_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
